core_wb_arbiter: RTL

CORE_WB_ARBITER -- requirements
Module: core_wb_arbiter

---
 rtl/core_wb_arbiter_if.sv | 22 ++
 rtl/core_wb_arbiter.sv | 49 ++++
 2 files changed

// File: rtl/core_wb_arbiter_if.sv
// core_wb_arbiter_if: ALU/LSU write-back request channels and the register-file write port
interface core_wb_arbiter_if #(parameter int DATA_W = 32);
  logic alu_valid_i;
  logic [4:0] alu_rd_i;
  logic [DATA_W-1:0] alu_data_i;
  logic alu_ready_o;
  logic lsu_valid_i;
  logic [4:0] lsu_rd_i;
  logic [DATA_W-1:0] lsu_data_i;
  logic lsu_ready_o;
  logic wb_we_o;
  logic [4:0] wb_rd_o;
  logic [DATA_W-1:0] wb_data_o;
  modport slave (
    input alu_valid_i, alu_rd_i, alu_data_i, lsu_valid_i, lsu_rd_i, lsu_data_i,
    output alu_ready_o, lsu_ready_o, wb_we_o, wb_rd_o, wb_data_o
  );
  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i, lsu_valid_i, lsu_rd_i, lsu_data_i,
    input alu_ready_o, lsu_ready_o, wb_we_o, wb_rd_o, wb_data_o
  );
endinterface

// File: rtl/core_wb_arbiter.sv
// core_wb_arbiter: round-robin ALU/LSU write-back arbiter with registered write port and saturating conflict counter
module core_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W = 16
) (
  input logic clk_i,
  input logic rst_i,
  input logic stall_i,
  core_wb_arbiter_if.slave bus,
  output logic [CNT_W-1:0] conflict_cnt_o
);
  logic go, conflict, alu_gnt, lsu_gnt;
  logic prio_q, prio_d, we_q, we_d;
  logic [4:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    go = !rst_i && !stall_i;
    conflict = bus.alu_valid_i && bus.lsu_valid_i;
    alu_gnt = go && bus.alu_valid_i && !(bus.lsu_valid_i && prio_q);
    lsu_gnt = go && bus.lsu_valid_i && !(bus.alu_valid_i && !prio_q);
    prio_d = (go && conflict) ? !prio_q : prio_q;
    cnt_d = (go && conflict && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    we_d = stall_i ? we_q : alu_gnt ? |bus.alu_rd_i : lsu_gnt ? |bus.lsu_rd_i : 1'b0;
    rd_d = alu_gnt ? bus.alu_rd_i : lsu_gnt ? bus.lsu_rd_i : rd_q;
    data_d = alu_gnt ? bus.alu_data_i : lsu_gnt ? bus.lsu_data_i : data_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
      we_q <= 1'b0;
      rd_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
    end else begin
      prio_q <= prio_d;
      we_q <= we_d;
      rd_q <= rd_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.alu_ready_o = alu_gnt;
  assign bus.lsu_ready_o = lsu_gnt;
  assign bus.wb_we_o = we_q;
  assign bus.wb_rd_o = rd_q;
  assign bus.wb_data_o = data_q;
  assign conflict_cnt_o = cnt_q;
endmodule
